// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use stall
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              IdValid_i,
   input  logic [4:0]        IdRs_i,
   input  logic [4:0]        IdRt_i,
   input  logic [4:0]        IdRd_i,
   input  logic              UsesRs_i,
   input  logic              UsesRt_i,
   input  logic [DATA_W-1:0] RsData_i,
   input  logic [DATA_W-1:0] RtData_i,
   input  logic [DATA_W-1:0] Imm_i,
   input  logic [CTRL_W-1:0] Ctrl_i,
   input  logic [2:0]        ForwardRs_i,
   input  logic [2:0]        ForwardRt_i,
   input  logic [DATA_W-1:0] ExResult_i,
   input  logic [DATA_W-1:0] MemResult_i,
   input  logic              ExMemRead_i,
   input  logic [4:0]        ExRegisterRd_i,
   input  logic              Hold_i,
   input  logic              Flush_i,
   output logic              Stall_o,
   output logic              ExValid_o,
   output logic [4:0]        ExRs_o,
   output logic [4:0]        ExRt_o,
   output logic [4:0]        ExRd_o,
   output logic [DATA_W-1:0] ExRsData_o,
   output logic [DATA_W-1:0] ExRtData_o,
   output logic [DATA_W-1:0] ExImm_o,
   output logic [CTRL_W-1:0] ExCtrl_o,
   output logic [CNT_W-1:0]  BubbleCnt_o
);

   logic              ex_valid_q,   ex_valid_d;
   logic [4:0]        ex_rs_q,      ex_rs_d;
   logic [4:0]        ex_rt_q,      ex_rt_d;
   logic [4:0]        ex_rd_q,      ex_rd_d;
   logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
   logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
   logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
   logic [CTRL_W-1:0] ex_ctrl_q,    ex_ctrl_d;
   logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
   logic              flush_pend_q, flush_pend_d;

   logic [DATA_W-1:0] rs_mux;
   logic [DATA_W-1:0] rt_mux;
   logic              flush_eff;
   logic              load_use;
   logic              rs_hit;
   logic              rt_hit;

   // Operand forwarding muxes: EX result beats MEM result beats register file; bit 2 is don't-care.
   always_comb begin
      rs_mux = RsData_i;
      if (ForwardRs_i[1]) begin
         rs_mux = ExResult_i;
      end else if (ForwardRs_i[0]) begin
         rs_mux = MemResult_i;
      end
      rt_mux = RtData_i;
      if (ForwardRt_i[1]) begin
         rt_mux = ExResult_i;
      end else if (ForwardRt_i[0]) begin
         rt_mux = MemResult_i;
      end
   end

   // Load-use detection against the load currently in EX; r0 is never a real dependency.
   always_comb begin
      flush_eff = Flush_i | flush_pend_q;
      rs_hit    = UsesRs_i & (ExRegisterRd_i == IdRs_i);
      rt_hit    = UsesRt_i & (ExRegisterRd_i == IdRt_i);
      load_use  = IdValid_i & ex_valid_q & ExMemRead_i & (ExRegisterRd_i != 5'd0) & (rs_hit | rt_hit);
      Stall_o   = load_use & ~flush_eff & ~Hold_i & ~rst_i;
   end

   // Next-state selection: hold, then flush bubble, then load-use bubble, then normal latch.
   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_rs_d      = ex_rs_q;
      ex_rt_d      = ex_rt_q;
      ex_rd_d      = ex_rd_q;
      ex_rs_data_d = ex_rs_data_q;
      ex_rt_data_d = ex_rt_data_q;
      ex_imm_d     = ex_imm_q;
      ex_ctrl_d    = ex_ctrl_q;
      bubble_cnt_d = bubble_cnt_q;
      flush_pend_d = flush_pend_q;

      if (Hold_i) begin
         // A flush seen while frozen must not be lost; it is applied once the hold lifts.
         flush_pend_d = flush_pend_q | Flush_i;
      end else if (flush_eff || load_use) begin
         ex_valid_d   = 1'b0;
         ex_rs_d      = '0;
         ex_rt_d      = '0;
         ex_rd_d      = '0;
         ex_rs_data_d = '0;
         ex_rt_data_d = '0;
         ex_imm_d     = '0;
         ex_ctrl_d    = '0;
         if (flush_eff) begin
            flush_pend_d = 1'b0;
         end else if (bubble_cnt_q != {CNT_W{1'b1}}) begin
            bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         ex_valid_d   = IdValid_i;
         ex_rs_d      = IdRs_i;
         ex_rt_d      = IdRt_i;
         ex_rd_d      = IdRd_i;
         ex_rs_data_d = rs_mux;
         ex_rt_data_d = rt_mux;
         ex_imm_d     = Imm_i;
         ex_ctrl_d    = Ctrl_i;
      end
   end

   // Pipeline register bank with asynchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ex_valid_q   <= 1'b0;
         ex_rs_q      <= '0;
         ex_rt_q      <= '0;
         ex_rd_q      <= '0;
         ex_rs_data_q <= '0;
         ex_rt_data_q <= '0;
         ex_imm_q     <= '0;
         ex_ctrl_q    <= '0;
         bubble_cnt_q <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_rs_q      <= ex_rs_d;
         ex_rt_q      <= ex_rt_d;
         ex_rd_q      <= ex_rd_d;
         ex_rs_data_q <= ex_rs_data_d;
         ex_rt_data_q <= ex_rt_data_d;
         ex_imm_q     <= ex_imm_d;
         ex_ctrl_q    <= ex_ctrl_d;
         bubble_cnt_q <= bubble_cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign ExValid_o   = ex_valid_q;
   assign ExRs_o      = ex_rs_q;
   assign ExRt_o      = ex_rt_q;
   assign ExRd_o      = ex_rd_q;
   assign ExRsData_o  = ex_rs_data_q;
   assign ExRtData_o  = ex_rt_data_q;
   assign ExImm_o     = ex_imm_q;
   assign ExCtrl_o    = ex_ctrl_q;
   assign BubbleCnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed scoreboard bench for id_ex_stage
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int CW = 8;
   localparam int NW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          id_valid = 1'b0;
   logic [4:0]    id_rs = '0, id_rt = '0, id_rd = '0;
   logic          uses_rs = 1'b0, uses_rt = 1'b0;
   logic [DW-1:0] rs_data = '0, rt_data = '0, imm = '0;
   logic [CW-1:0] ctrl = '0;
   logic [2:0]    fwd_rs = '0, fwd_rt = '0;
   logic [DW-1:0] ex_result = '0, mem_result = '0;
   logic          ex_mem_read = 1'b0;
   logic [4:0]    ex_reg_rd = '0;
   logic          hold = 1'b0, flush = 1'b0;

   logic          stall, ex_valid;
   logic [4:0]    ex_rs, ex_rt, ex_rd;
   logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [CW-1:0] ex_ctrl;
   logic [NW-1:0] bub_cnt;

   id_ex_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
      .clk_i(clk), .rst_i(rst), .IdValid_i(id_valid), .IdRs_i(id_rs), .IdRt_i(id_rt), .IdRd_i(id_rd),
      .UsesRs_i(uses_rs), .UsesRt_i(uses_rt), .RsData_i(rs_data), .RtData_i(rt_data), .Imm_i(imm),
      .Ctrl_i(ctrl), .ForwardRs_i(fwd_rs), .ForwardRt_i(fwd_rt), .ExResult_i(ex_result),
      .MemResult_i(mem_result), .ExMemRead_i(ex_mem_read), .ExRegisterRd_i(ex_reg_rd),
      .Hold_i(hold), .Flush_i(flush), .Stall_o(stall), .ExValid_o(ex_valid), .ExRs_o(ex_rs),
      .ExRt_o(ex_rt), .ExRd_o(ex_rd), .ExRsData_o(ex_rs_data), .ExRtData_o(ex_rt_data),
      .ExImm_o(ex_imm), .ExCtrl_o(ex_ctrl), .BubbleCnt_o(bub_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic [4:0]    rs, rt, rd;
      logic [DW-1:0] rsd, rtd, im;
      logic [CW-1:0] ct;
      logic [NW-1:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   vectors = 0;
   int   errors  = 0;
   int   step    = 0;
   int   cnt     = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL step%0d %s observed=%h expected=%h", step, tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic v, input logic [4:0] rs, rt, rd,
                               input logic [DW-1:0] rsd, rtd, im, input logic [CW-1:0] ct);
      exp_t e;
      e.v = v; e.rs = rs; e.rt = rt; e.rd = rd;
      e.rsd = rsd; e.rtd = rtd; e.im = im; e.ct = ct;
      e.cnt = NW'(cnt);
      return e;
   endfunction

   function automatic exp_t bub();
      return mk(1'b0, 5'd0, 5'd0, 5'd0, '0, '0, '0, '0);
   endfunction

   task automatic id_in(input logic v, input logic [4:0] rs, rt, rd, input logic urs, urt,
                        input logic [DW-1:0] rsd, rtd, im, input logic [CW-1:0] ct,
                        input logic [2:0] frs, frt);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; uses_rs = urs; uses_rt = urt;
      rs_data = rsd; rt_data = rtd; imm = im; ctrl = ct; fwd_rs = frs; fwd_rt = frt;
   endtask

   task automatic ex_in(input logic mr, input logic [4:0] rd);
      ex_mem_read = mr; ex_reg_rd = rd;
   endtask

   task automatic check_outputs(input exp_t e);
      chk("ExValid", 64'(ex_valid), 64'(e.v));
      chk("ExRs", 64'(ex_rs), 64'(e.rs));
      chk("ExRt", 64'(ex_rt), 64'(e.rt));
      chk("ExRd", 64'(ex_rd), 64'(e.rd));
      chk("ExRsData", 64'(ex_rs_data), 64'(e.rsd));
      chk("ExRtData", 64'(ex_rt_data), 64'(e.rtd));
      chk("ExImm", 64'(ex_imm), 64'(e.im));
      chk("ExCtrl", 64'(ex_ctrl), 64'(e.ct));
      chk("BubbleCnt", 64'(bub_cnt), 64'(e.cnt));
   endtask

   // Inputs are driven 1 time unit after an edge; stall is checked before the edge, outputs after.
   task automatic tick(input exp_t e, input logic exp_stall);
      exp_t got;
      step++;
      sb.push_back(e);
      #1;
      chk("Stall", 64'(stall), 64'(exp_stall));
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL step%0d scoreboard underflow", step);
      end else begin
         got = sb.pop_front();
         check_outputs(got);
         last = got;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      @(posedge clk);
      #1;
      check_outputs(bub());
      chk("Stall_reset", 64'(stall), 64'd0);
      rst = 1'b0;

      // Plain latch: add r3 = r1 + r2
      id_in(1, 1, 2, 3, 1, 1, 5, 7, 'h10, 'h21, 3'b000, 3'b000);
      ex_in(0, 0);
      tick(mk(1, 1, 2, 3, 5, 7, 'h10, 'h21), 0);

      // Forwarding selects, including both bits set and bit2-only
      ex_result = 'hAA; mem_result = 'hBB;
      id_in(1, 1, 2, 5, 1, 1, 5, 7, 'h20, 'h22, 3'b011, 3'b101);
      tick(mk(1, 1, 2, 5, 'hAA, 'hBB, 'h20, 'h22), 0);
      id_in(1, 6, 7, 8, 1, 1, 'h11, 'h22, 'h30, 'h23, 3'b100, 3'b010);
      tick(mk(1, 6, 7, 8, 'h11, 'hAA, 'h30, 'h23), 0);

      // Load to r4 enters EX, dependent instruction stalls once, then latches with MEM forward
      id_in(1, 1, 2, 4, 1, 1, 5, 7, 'h40, 'h81, 3'b000, 3'b000);
      tick(mk(1, 1, 2, 4, 5, 7, 'h40, 'h81), 0);
      id_in(1, 1, 4, 9, 1, 1, 5, 'h77, 'h50, 'h24, 3'b000, 3'b000);
      ex_in(1, 4);
      cnt = 1;
      tick(bub(), 1);
      mem_result = 'h44;
      id_in(1, 1, 4, 9, 1, 1, 5, 'h77, 'h50, 'h24, 3'b000, 3'b001);
      tick(mk(1, 1, 4, 9, 5, 'h44, 'h50, 'h24), 0);

      // Load to r0 is never a hazard; unused Rt match is not a hazard
      id_in(1, 1, 2, 0, 1, 1, 5, 7, 0, 'h81, 3'b000, 3'b000);
      ex_in(0, 0);
      tick(mk(1, 1, 2, 0, 5, 7, 0, 'h81), 0);
      id_in(1, 0, 2, 10, 1, 1, 0, 7, 0, 'h25, 3'b000, 3'b000);
      ex_in(1, 0);
      tick(mk(1, 0, 2, 10, 0, 7, 0, 'h25), 0);
      id_in(1, 1, 4, 11, 1, 0, 5, 'h66, 0, 'h26, 3'b000, 3'b000);
      ex_in(1, 4);
      tick(mk(1, 1, 4, 11, 5, 'h66, 0, 'h26), 0);

      // Hold for 3 cycles with a flush pulse in the 2nd, with a live hazard on the inputs
      hold = 1'b1;
      id_in(1, 4, 2, 12, 1, 1, 'h12, 'h13, 'h60, 'h27, 3'b000, 3'b000);
      tick(last, 0);
      flush = 1'b1;
      tick(last, 0);
      flush = 1'b0;
      tick(last, 0);
      hold = 1'b0;
      tick(bub(), 0);
      tick(mk(1, 4, 2, 12, 'h12, 'h13, 'h60, 'h27), 0);

      // Flush during a load-use hazard: bubble, no stall, counter unchanged
      id_in(1, 3, 3, 4, 1, 1, 1, 1, 0, 'h81, 3'b000, 3'b000);
      ex_in(0, 0);
      tick(mk(1, 3, 3, 4, 1, 1, 0, 'h81), 0);
      id_in(1, 4, 5, 13, 1, 1, 2, 3, 0, 'h28, 3'b000, 3'b000);
      ex_in(1, 4);
      flush = 1'b1;
      tick(bub(), 0);
      flush = 1'b0;

      // Drive the counter to saturation and one beyond
      for (int i = 0; i < 16; i++) begin
         id_in(1, 1, 2, 4, 1, 1, DW'(i), DW'(i + 1), DW'(i * 3), 'h81, 3'b000, 3'b000);
         ex_in(0, 0);
         tick(mk(1, 1, 2, 4, DW'(i), DW'(i + 1), DW'(i * 3), 'h81), 0);
         id_in(1, 2, 4, 14, 1, 1, 0, 0, 0, 'h29, 3'b000, 3'b000);
         ex_in(1, 4);
         if (cnt < 15) cnt++;
         tick(bub(), 1);
      end
      chk("BubbleCnt_sat", 64'(bub_cnt), 64'hF);

      // Reset asserted mid-stall clears everything immediately
      id_in(1, 1, 2, 4, 1, 1, 9, 9, 0, 'h81, 3'b000, 3'b000);
      ex_in(0, 0);
      tick(mk(1, 1, 2, 4, 9, 9, 0, 'h81), 0);
      id_in(1, 4, 2, 15, 1, 1, 'h21, 'h22, 'h23, 'h2A, 3'b000, 3'b000);
      ex_in(1, 4);
      #1;
      chk("Stall_pre_rst", 64'(stall), 64'd1);
      rst = 1'b1;
      #1;
      cnt = 0;
      check_outputs(bub());
      chk("Stall_in_rst", 64'(stall), 64'd0);
      rst = 1'b0;
      tick(mk(1, 4, 2, 15, 'h21, 'h22, 'h23, 'h2A), 0);

      // Reset with a pending flush: first edge after release latches normally
      hold = 1'b1;
      flush = 1'b1;
      tick(last, 0);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      hold = 1'b0;
      flush = 1'b0;
      ex_in(0, 0);
      id_in(1, 7, 8, 9, 1, 1, 'h31, 'h32, 'h33, 'h2B, 3'b000, 3'b000);
      tick(mk(1, 7, 8, 9, 'h31, 'h32, 'h33, 'h2B), 0);

      if (sb.size() != 0) begin
         errors++;
         $error("FAIL scoreboard leftover %0d", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
